// File: rtl/bin2bcd_display_source_pkg.sv
// Shared encodings and sizing for the binary-to-BCD display source.
// The BCD accumulator is always five digits wide, independent of the binary width.
package bin2bcd_display_source_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGITS = 5;
   localparam int BCD_W      = 4 * BCD_DIGITS;

endpackage

// File: rtl/bin2bcd_display_source_bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
// Four-bit wraparound is intentional; no carry leaves the nibble.
module bin2bcd_display_source_bcd_add3 (
   input  logic [3:0] nibble,
   output logic [3:0] adjusted
);

   always_comb begin
      // NOTE: the output takes a default before the conditional so no latch is inferred.
      adjusted = nibble;
      if (nibble >= 4'd5) begin
         adjusted = nibble + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_display_source.sv
// Sequential double-dabble converter feeding four BCD digits to the display controller.
// Digit holding registers update only on the completion edge, so the display never sees partial results.
module bin2bcd_display_source
   import bin2bcd_display_source_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [3:0]       d1,
   output logic [3:0]       d2,
   output logic [3:0]       d3,
   output logic [3:0]       d4,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t                   state;
   logic [WIDTH-1:0]         shift_reg;
   logic [BCD_W-1:0]         bcd;
   logic [CW-1:0]            cnt;

   logic [BCD_W-1:0]         bcd_adj;
   logic [BCD_W+WIDTH-1:0]   shifted;
   logic [BCD_W-1:0]         next_bcd;
   logic [WIDTH-1:0]         next_shift;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
      bin2bcd_display_source_bcd_add3 u_add3 (
         .nibble   (bcd[4*g +: 4]),
         .adjusted (bcd_adj[4*g +: 4])
      );
   end

   // The shift MSB crosses into the BCD LSB by shifting the concatenation as one word.
   assign shifted    = {bcd_adj, shift_reg} << 1;
   assign next_bcd   = shifted[BCD_W+WIDTH-1:WIDTH];
   assign next_shift = shifted[WIDTH-1:0];

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bcd       <= '0;
         cnt       <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         d4        <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= value;
                  bcd       <= '0;
                  cnt       <= CW'(WIDTH - 1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               bcd       <= next_bcd;
               shift_reg <= next_shift;
               cnt       <= cnt - 1'b1;
               if (cnt == '0) begin
                  d1       <= next_bcd[15:12];
                  d2       <= next_bcd[11:8];
                  d3       <= next_bcd[7:4];
                  d4       <= next_bcd[3:0];
                  overflow <= |next_bcd[19:16];
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_display_source.sv
// Directed bench for the BCD display source: 16-bit and 8-bit instances, hand-computed digits.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_bin2bcd_display_source;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] value;
   logic        busy, done, overflow;
   logic [3:0]  d1, d2, d3, d4;

   logic        start8;
   logic [7:0]  value8;
   logic        busy8, done8, overflow8;
   logic [3:0]  e1, e2, e3, e4;

   int          n_cmp;
   int          n_err;
   logic [16:0] prev16;

   logic [16:0] res16;
   logic [16:0] res8;
   assign res16 = {overflow, d1, d2, d3, d4};
   assign res8  = {overflow8, e1, e2, e3, e4};

   bin2bcd_display_source #(.WIDTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .value    (value),
      .busy     (busy),
      .done     (done),
      .d1       (d1),
      .d2       (d2),
      .d3       (d3),
      .d4       (d4),
      .overflow (overflow)
   );

   bin2bcd_display_source #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .reset    (reset),
      .start    (start8),
      .value    (value8),
      .busy     (busy8),
      .done     (done8),
      .d1       (e1),
      .d2       (e2),
      .d3       (e3),
      .d4       (e4),
      .overflow (overflow8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Call on a falling edge with the 16-bit DUT idle; returns two falling edges after done.
   task automatic conv16(input logic [15:0] v, input logic [16:0] exp, input string tag);
      int   nb;
      logic stable;
      start = 1'b1;
      value = v;
      @(negedge clk);
      start  = 1'b0;
      value  = ~v;
      nb     = 0;
      stable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (busy === 1'b1 && done === 1'b0) nb++;
         if (res16 !== prev16) stable = 1'b0;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, nb, 16);
      check({tag, " digits_stable"}, 32'(stable), 1);
      check({tag, " done_pulse"}, {busy, done}, 2'b01);
      check({tag, " digits"}, res16, exp);
      @(negedge clk);
      check({tag, " done_width"}, {busy, done}, 2'b00);
      check({tag, " digits_hold"}, res16, exp);
      prev16 = exp;
   endtask

   initial begin
      int nb;
      int nd;
      int dpos[3];

      n_cmp  = 0;
      n_err  = 0;
      prev16 = '0;
      reset  = 1'b1;
      start  = 1'b0;
      value  = '0;
      start8 = 1'b0;
      value8 = '0;

      repeat (2) @(negedge clk);
      check("reset16", {busy, done, res16}, '0);
      check("reset8", {busy8, done8, res8}, '0);
      reset = 1'b0;
      @(negedge clk);

      // 8-bit instance: 255 converts in 8 shift cycles
      start8 = 1'b1;
      value8 = 8'd255;
      @(negedge clk);
      start8 = 1'b0;
      value8 = 8'd0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy8 === 1'b1 && done8 === 1'b0) nb++;
         @(negedge clk);
      end
      check("w8 busy_cycles", nb, 8);
      check("w8 done_pulse", {busy8, done8}, 2'b01);
      check("w8 digits", res8, 17'h00255);
      @(negedge clk);
      check("w8 done_width", {busy8, done8}, 2'b00);

      conv16(16'd1234, 17'h01234, "v1234");
      conv16(16'd9999, 17'h09999, "v9999");
      conv16(16'd10000, 17'h10000, "v10000");
      conv16(16'd65535, 17'h15535, "v65535");
      conv16(16'd0, 17'h00000, "v0");

      // start held high: accepts every 18 cycles, done at 16/34/52 after the first accept
      start = 1'b1;
      value = 16'd42;
      nb = 0;
      nd = 0;
      for (int k = 0; k < 54; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (nd < 3) dpos[nd] = k;
            nd++;
         end
         if (busy === 1'b1) nb++;
      end
      start = 1'b0;
      check("held done_count", nd, 3);
      check("held done_pos0", dpos[0], 16);
      check("held done_pos1", dpos[1], 34);
      check("held done_pos2", dpos[2], 52);
      check("held busy_cycles", nb, 48);
      check("held digits", res16, 17'h00042);

      // asynchronous reset in the 8th shift cycle of 4321
      start = 1'b1;
      value = 16'd4321;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_reset busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_reset ctrl", {busy, done}, 2'b00);
      check("async_reset digits", res16, 17'h00000);
      check("async_reset digits8", res8, 17'h00000);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) nd++;
      end
      check("post_reset quiet", nd, 0);
      prev16 = '0;
      conv16(16'd4321, 17'h04321, "v4321");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
